spi_apb_master: RTL and testbench

//  SPI-slave (mode 0) to multi-bank APB master bridge. Deserialises one fixed-length command frame per ss-low window.

---
 rtl/spi2apb_pkg.sv | 22 ++
 rtl/spi2apb_shifter.sv | 78 +++++++
 rtl/spi_apb_master.sv | 182 ++++++++++++++++++
 tb/tb_spi_apb_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi2apb_pkg.sv
// spi2apb_pkg: shared types and helpers for the SPI-to-APB bridge
// FSM states, status word slots and MSB-relative field offsets
package spi2apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   // Status slots, counted from the MSB of the response word
   localparam int ST_BUSY = 0;
   localparam int ST_ERR  = 1;
   localparam int ST_OVR  = 2;
   localparam int ST_NUM  = 3;

   // Bit index of slot pos counted from the MSB of a w-bit word
   function automatic int msb_off(input int w, input int pos);
      return w - 1 - pos;
   endfunction

endpackage

// File: rtl/spi2apb_shifter.sv
// spi2apb_shifter: SPI mode-0 RX/TX shift registers and bit counter
// Emits a one-cycle frame_done after the last frame bit is sampled
module spi2apb_shifter
   import spi2apb_pkg::*;
#(
   parameter int FRAME_W = 18
) (
   input  logic               sclk_i,
   input  logic               resetn_i,
   input  logic               mosi_i,
   input  logic               ss_i,
   input  logic [FRAME_W-1:0] resp_i,
   output logic               miso_o,
   output logic [FRAME_W-1:0] frame_o,
   output logic               frame_done_o,
   output logic               first_bit_o,
   output logic               sent_err_o,
   output logic               sent_ovr_o
);

   localparam int CNT_W = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_W);

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FRAME_W-1:0] rx_q, rx_d;
   logic [FRAME_W-1:0] tx_q;
   logic               done_q, done_d;
   logic               smp_q;

   // RX next state: shift while selected, saturate past the frame length
   always_comb begin
      cnt_d  = cnt_q;
      rx_d   = rx_q;
      done_d = 1'b0;
      if (ss_i) begin
         cnt_d = '0;
      end else if (cnt_q != FULL) begin
         cnt_d  = cnt_q + 1'b1;
         rx_d   = {rx_q[FRAME_W-2:0], mosi_i};
         done_d = (cnt_q == LAST);
      end
   end

   // RX registers on the sampling edge
   always_ff @(posedge sclk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         cnt_q  <= '0;
         rx_q   <= '0;
         done_q <= 1'b0;
         smp_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rx_q   <= rx_d;
         done_q <= done_d;
         smp_q  <= !ss_i;
      end
   end

   // TX: reload while deselected, shift after every sampled bit
   always_ff @(negedge sclk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         tx_q <= '0;
      end else if (ss_i) begin
         tx_q <= resp_i;
      end else if (smp_q) begin
         tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
      end
   end

   assign miso_o       = tx_q[FRAME_W-1];
   assign frame_o      = rx_q;
   assign frame_done_o = done_q;
   assign first_bit_o  = !ss_i && (cnt_q == '0);
   assign sent_err_o   = tx_q[msb_off(FRAME_W, ST_ERR)];
   assign sent_ovr_o   = tx_q[msb_off(FRAME_W, ST_OVR)];

endmodule

// File: rtl/spi_apb_master.sv
// spi_apb_master: SPI mode-0 slave to multi-bank APB master bridge
// Optional ACCESS timeout enabled by defining SPI2APB_TIMEOUT_EN
module spi_apb_master
   import spi2apb_pkg::*;
#(
   parameter int BANK_NUM       = 3,
   parameter int DATA_WIDTH     = 8,
`ifdef SPI2APB_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = 16,
`endif
   parameter int ADDR_WIDTH     = 7
) (
   input  logic                  sclk,
   input  logic                  resetn,
   input  logic                  mosi,
   input  logic                  ss,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] b_prdata,
   input  logic                  b_pready,
   output logic                  b_pclk,
   output logic                  b_resetn,
   output logic [DATA_WIDTH-1:0] b_pwdata,
   output logic                  b_pwrite,
   output logic [BANK_NUM-1:0]   b_psel,
   output logic                  b_penable,
   output logic [ADDR_WIDTH-1:0] b_paddr
);

   localparam int BANK_W  = $clog2(BANK_NUM);
   localparam int FRAME_W = 1 + BANK_W + ADDR_WIDTH + DATA_WIDTH;
   localparam int PAD_W   = FRAME_W - ST_NUM - DATA_WIDTH;
   localparam logic [BANK_W:0] BANK_LIM = (BANK_W + 1)'(BANK_NUM);
   localparam logic [BANK_NUM-1:0] SEL1 = {{(BANK_NUM-1){1'b0}}, 1'b1};
`ifdef SPI2APB_TIMEOUT_EN
   localparam int T_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT_CYCLES - 1);
   logic [T_W-1:0] tcnt_q, tcnt_d;
`endif

   state_e state_q, state_d;
   logic                  wr_q, wr_d;
   logic [BANK_W-1:0]     bank_q, bank_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  ovr_q, ovr_d;
   logic                  err_evt, ovr_evt;

   logic [FRAME_W-1:0]    frame;
   logic [FRAME_W-1:0]    resp;
   logic                  frame_done, first_bit;
   logic                  sent_err, sent_ovr;
   logic                  busy;

   logic                  f_wr;
   logic [BANK_W-1:0]     f_bank;
   logic [ADDR_WIDTH-1:0] f_addr;
   logic [DATA_WIDTH-1:0] f_wdata;

   assign f_wr    = frame[msb_off(FRAME_W, 0)];
   assign f_bank  = frame[msb_off(FRAME_W, 1) -: BANK_W];
   assign f_addr  = frame[DATA_WIDTH +: ADDR_WIDTH];
   assign f_wdata = frame[DATA_WIDTH-1:0];

   assign busy = (state_q != IDLE);
   assign resp = {busy, err_q, ovr_q, {PAD_W{1'b0}}, rdata_q};

   assign b_pclk   = sclk;
   assign b_resetn = resetn;

   spi2apb_shifter #(
      .FRAME_W (FRAME_W)
   ) u_shift (
      .sclk_i       (sclk),
      .resetn_i     (resetn),
      .mosi_i       (mosi),
      .ss_i         (ss),
      .resp_i       (resp),
      .miso_o       (miso),
      .frame_o      (frame),
      .frame_done_o (frame_done),
      .first_bit_o  (first_bit),
      .sent_err_o   (sent_err),
      .sent_ovr_o   (sent_ovr)
   );

   // Next state: accept frames in IDLE, run SETUP/ACCESS, raise events
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      bank_d  = bank_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_evt = 1'b0;
      ovr_evt = 1'b0;
`ifdef SPI2APB_TIMEOUT_EN
      tcnt_d  = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (frame_done) begin
               if ({1'b0, f_bank} < BANK_LIM) begin
                  state_d = SETUP;
                  wr_d    = f_wr;
                  bank_d  = f_bank;
                  addr_d  = f_addr;
                  wdata_d = f_wdata;
               end else begin
                  err_evt = 1'b1;
               end
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (b_pready) begin
               state_d = IDLE;
               if (!wr_q) rdata_d = b_prdata;
            end
`ifdef SPI2APB_TIMEOUT_EN
            else if (tcnt_q == T_LAST) begin
               state_d = IDLE;
               err_evt = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      if (frame_done && busy) ovr_evt = 1'b1;
      err_d = (err_q & ~(first_bit & sent_err)) | err_evt;
      ovr_d = (ovr_q & ~(first_bit & sent_ovr)) | ovr_evt;
   end

   // Bridge state, captured request, read data and sticky status
   always_ff @(posedge sclk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         bank_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef SPI2APB_TIMEOUT_EN
         tcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
`ifdef SPI2APB_TIMEOUT_EN
         tcnt_q  <= tcnt_d;
`endif
      end
   end

   // APB outputs: driven from the captured request, zero in IDLE
   always_comb begin
      b_psel    = '0;
      b_penable = 1'b0;
      b_paddr   = '0;
      b_pwdata  = '0;
      b_pwrite  = 1'b0;
      if (busy) begin
         b_psel    = SEL1 << bank_q;
         b_penable = (state_q == ACCESS);
         b_paddr   = addr_q;
         b_pwdata  = wdata_q;
         b_pwrite  = wr_q;
      end
   end

endmodule

// File: tb/tb_spi_apb_master.sv
// tb_spi_apb_master: randomized scoreboard bench for spi_apb_master
// Reference model tracks flags/read data; monitors check APB and miso
module tb_spi_apb_master;

   localparam int FW = 18;

   logic       sclk = 1'b0;
   logic       resetn = 1'b0;
   logic       mosi = 1'b0;
   logic       ss = 1'b1;
   logic       miso;
   logic [7:0] b_prdata = 8'h00;
   logic       b_pready = 1'b0;
   logic       b_pclk;
   logic       b_resetn;
   logic [7:0] b_pwdata;
   logic       b_pwrite;
   logic [2:0] b_psel;
   logic       b_penable;
   logic [6:0] b_paddr;

   spi_apb_master dut (
      .sclk      (sclk),
      .resetn    (resetn),
      .mosi      (mosi),
      .ss        (ss),
      .miso      (miso),
      .b_prdata  (b_prdata),
      .b_pready  (b_pready),
      .b_pclk    (b_pclk),
      .b_resetn  (b_resetn),
      .b_pwdata  (b_pwdata),
      .b_pwrite  (b_pwrite),
      .b_psel    (b_psel),
      .b_penable (b_penable),
      .b_paddr   (b_paddr)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      logic [2:0] psel;
      logic [6:0] addr;
      logic [7:0] data;
      logic       wr;
      int         ncyc;
   } apb_t;

   typedef struct {
      int         wait_c;
      logic [7:0] rdata;
   } slv_t;

   apb_t        apb_q[$];
   slv_t        slv_q[$];
   logic [17:0] resp_q[$];

   int   checks = 0;
   int   failures = 0;
   bit   abort_exp = 1'b0;
   logic m_err = 1'b0;
   logic m_ovr = 1'b0;
   logic [7:0] m_rdata = 8'h00;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: event seen, none expected", nm);
   endtask

   // Host side: send nbits (extra bits random), then hold ss high gap cycles
   task automatic send(input logic [17:0] f, input int nbits,
                       input int gap, input logic busy);
      resp_q.push_back({busy, m_err, m_ovr, 7'b0, m_rdata});
      m_err = 1'b0;
      m_ovr = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         @(negedge sclk);
         #1;
         ss = 1'b0;
         if (i < FW) mosi = f[FW-1-i];
         else mosi = 1'($urandom_range(0, 1));
      end
      @(negedge sclk);
      #1;
      ss = 1'b1;
      mosi = 1'b0;
      repeat (gap - 1) @(negedge sclk);
   endtask

   task automatic do_txn(input logic wr, input logic [1:0] bank,
                         input logic [6:0] addr, input logic [7:0] d,
                         input int w, input logic [7:0] prd,
                         input int extra, input int gap);
      logic [17:0] f;
      int ncyc;
      bit tmo;
      f = {wr, bank, addr, d};
      ncyc = w + 1;
      tmo = 1'b0;
`ifdef SPI2APB_TIMEOUT_EN
      if (w >= 16) begin
         ncyc = 16;
         tmo = 1'b1;
      end
`endif
      if (bank != 2'd3) begin
         slv_q.push_back('{w, prd});
         apb_q.push_back('{3'b001 << bank, addr, d, wr, ncyc});
      end
      send(f, FW + extra, gap, 1'b0);
      if (bank == 2'd3 || tmo) m_err = 1'b1;
      else if (!wr) m_rdata = prd;
   endtask

   // APB slave: ready after wait_c extra ACCESS cycles
   initial begin
      int cnt;
      slv_t cur;
      cnt = 0;
      cur.wait_c = 0;
      cur.rdata = 8'h00;
      forever begin
         @(negedge sclk);
         if (b_penable) begin
            if (cnt == 0 && slv_q.size() > 0) cur = slv_q.pop_front();
            b_prdata = cur.rdata;
            b_pready = (cnt >= cur.wait_c);
            cnt++;
         end else begin
            cnt = 0;
            b_pready = 1'b0;
         end
      end
   end

   // APB monitor: check SETUP, ACCESS fields, length and idle zeros
   initial begin
      logic pe_prev;
      logic [2:0] psel_prev;
      int acc;
      bit have;
      apb_t cur;
      pe_prev = 1'b0;
      psel_prev = 3'b000;
      acc = 0;
      have = 1'b0;
      forever begin
         @(negedge sclk);
         if (b_penable && !pe_prev) begin
            acc = 0;
            if (apb_q.size() == 0) begin
               fail("apb_unexpected_access");
            end else begin
               cur = apb_q.pop_front();
               have = 1'b1;
               chk("apb_setup_psel", 32'(psel_prev), 32'(cur.psel));
               chk("apb_psel", 32'(b_psel), 32'(cur.psel));
               chk("apb_paddr", 32'(b_paddr), 32'(cur.addr));
               chk("apb_pwdata", 32'(b_pwdata), 32'(cur.data));
               chk("apb_pwrite", 32'(b_pwrite), 32'(cur.wr));
            end
         end
         if (b_penable && have) begin
            acc++;
            chk("apb_hold", {15'b0, b_psel, b_paddr, b_pwdata, b_pwrite},
                {15'b0, cur.psel, cur.addr, cur.data, cur.wr});
         end
         if (!b_penable && pe_prev && have) begin
            if (abort_exp) abort_exp = 1'b0;
            else chk("apb_access_len", 32'(acc), 32'(cur.ncyc));
            chk("apb_idle_zero", {13'b0, b_psel, b_paddr, b_pwdata, b_pwrite},
                32'd0);
            have = 1'b0;
         end
         if (b_psel != 3'b000 && !b_penable && !have && apb_q.size() == 0)
            fail("apb_unexpected_setup");
         pe_prev = b_penable;
         psel_prev = b_psel;
      end
   end

   // SPI monitor: collect miso per ss-low window, compare sent prefix
   initial begin
      logic sp;
      bit inf;
      int n;
      logic [17:0] w, e, mask;
      sp = 1'b1;
      inf = 1'b0;
      n = 0;
      w = '0;
      forever begin
         @(posedge sclk);
         if (!ss && sp) begin
            inf = 1'b1;
            n = 0;
            w = '0;
         end
         if (!ss && inf && n < FW) begin
            w[FW-1-n] = miso;
            n++;
         end
         if (ss && !sp && inf) begin
            inf = 1'b0;
            if (resp_q.size() == 0) begin
               fail("miso_unexpected_frame");
            end else begin
               e = resp_q.pop_front();
               mask = '0;
               for (int i = 0; i < n; i++) mask[FW-1-i] = 1'b1;
               chk("miso_resp", 32'(w & mask), 32'(e & mask));
            end
         end
         sp = ss;
      end
   end

   initial begin
      logic [17:0] f;
      int kind, w, extra;
      logic wr;
      logic [1:0] bank;
      logic [6:0] addr;
      logic [7:0] d, prd;

      #2;
      chk("rst_psel", 32'(b_psel), 32'd0);
      chk("rst_penable", 32'(b_penable), 32'd0);
      chk("rst_pwrite", 32'(b_pwrite), 32'd0);
      chk("rst_paddr", 32'(b_paddr), 32'd0);
      chk("rst_pwdata", 32'(b_pwdata), 32'd0);
      chk("rst_miso", 32'(miso), 32'd0);
      repeat (3) @(negedge sclk);
      #1;
      resetn = 1'b1;
      repeat (3) @(negedge sclk);

      do_txn(1'b1, 2'd1, 7'h05, 8'hA5, 0, 8'h00, 0, 6);
      do_txn(1'b0, 2'd2, 7'h10, 8'h00, 3, 8'h3C, 0, 9);
      do_txn(1'b1, 2'd3, 7'h11, 8'h22, 0, 8'h00, 0, 6);
      do_txn(1'b1, 2'd0, 7'h12, 8'h33, 1, 8'h00, 0, 7);
      do_txn(1'b0, 2'd1, 7'h13, 8'h00, 0, 8'hC7, 0, 6);
      f = {1'b1, 2'd0, 7'h44, 8'h55};
      send(f, 10, 6, 1'b0);
      do_txn(1'b1, 2'd2, 7'h20, 8'h99, 2, 8'h00, 0, 8);

      slv_q.push_back('{30, 8'h5A});
      apb_q.push_back('{3'b100, 7'h22, 8'h00, 1'b0, 31});
      f = {1'b0, 2'd2, 7'h22, 8'h00};
      send(f, FW, 2, 1'b0);
      f = {1'b1, 2'd0, 7'h23, 8'h77};
      send(f, FW, 25, 1'b1);
      m_ovr = 1'b1;
      m_rdata = 8'h5A;
      do_txn(1'b1, 2'd1, 7'h24, 8'h66, 0, 8'h00, 0, 6);

`ifdef SPI2APB_TIMEOUT_EN
      do_txn(1'b0, 2'd0, 7'h30, 8'h00, 40, 8'hBB, 0, 30);
`else
      do_txn(1'b0, 2'd0, 7'h30, 8'h00, 20, 8'hBB, 0, 30);
`endif
      do_txn(1'b1, 2'd0, 7'h31, 8'h01, 0, 8'h00, 0, 6);

      for (int k = 0; k < 40; k++) begin
         kind = $urandom_range(0, 9);
         wr = 1'($urandom_range(0, 1));
         bank = 2'($urandom_range(0, 3));
         addr = 7'($urandom_range(0, 127));
         d = 8'($urandom_range(0, 255));
         prd = 8'($urandom_range(0, 255));
         w = $urandom_range(0, 4);
         extra = (kind == 1) ? $urandom_range(1, 5) : 0;
         if (kind == 0) begin
            f = {wr, bank, addr, d};
            send(f, $urandom_range(1, FW - 1), 4, 1'b0);
         end else begin
            do_txn(wr, bank, addr, d, w, prd, extra, w + 6);
         end
      end

      slv_q.push_back('{200, 8'hEE});
      apb_q.push_back('{3'b010, 7'h33, 8'h00, 1'b0, 0});
      abort_exp = 1'b1;
      f = {1'b0, 2'd1, 7'h33, 8'h00};
      send(f, FW, 8, 1'b0);
      #1;
      resetn = 1'b0;
      #1;
      chk("mid_rst_psel", 32'(b_psel), 32'd0);
      chk("mid_rst_penable", 32'(b_penable), 32'd0);
      chk("mid_rst_pwrite", 32'(b_pwrite), 32'd0);
      chk("mid_rst_paddr", 32'(b_paddr), 32'd0);
      chk("mid_rst_pwdata", 32'(b_pwdata), 32'd0);
      chk("mid_rst_miso", 32'(miso), 32'd0);
      m_err = 1'b0;
      m_ovr = 1'b0;
      m_rdata = 8'h00;
      repeat (3) @(negedge sclk);
      #1;
      resetn = 1'b1;
      repeat (3) @(negedge sclk);
      do_txn(1'b0, 2'd2, 7'h40, 8'h00, 1, 8'h81, 0, 7);
      do_txn(1'b1, 2'd1, 7'h41, 8'h42, 0, 8'h00, 0, 6);

      repeat (40) @(negedge sclk);
      chk("apb_q_empty", 32'(apb_q.size()), 32'd0);
      chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
      chk("slv_q_empty", 32'(slv_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
